instr_halfword_assembler: RTL and testbench

- Sits between instruction memory and the instruction decoder.
- Accepts a stream of 16-bit halfwords and assembles them into complete variable-length instructions of 16, 32 or 48 bits, using the group field in halfword 0.
- Presents each instruction left-aligned in the 48-bit decode word, with its byte address and length, over a valid/ready handshake.
- Supports a synchronous flush with address reload for branches.

---
 rtl/instr_halfword_assembler.sv | 132 +++++++++++++
 tb/tb_instr_halfword_assembler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_halfword_assembler.sv
// Assembles 16/32/48-bit instructions from a 16-bit halfword stream.
// Each instruction is presented left-aligned to the decoder over valid/ready.
module instr_halfword_assembler #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       hw_in,
  input  logic              hw_valid,
  output logic              hw_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic [47:0]       instr,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] HW_STEP = ADDR_W'(2);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        need_q, need_d;
  logic [1:0]        len_q, len_d;
  logic [47:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic              hw_acc;
  logic              xfer;
  logic [1:0]        first_len;

  // Instruction length in halfwords, taken from the group field of hw0.
  function automatic logic [1:0] hw_len(input logic [15:0] hw);
    case (hw[15:14])
      2'b00:        hw_len = 2'd1;
      2'b01, 2'b10: hw_len = 2'd2;
      2'b11:        hw_len = 2'd3;
      default:      hw_len = 2'd2;
    endcase
  endfunction

  assign hw_ready  = !flush && ((state_q == COLLECT) || instr_ready);
  assign hw_acc    = hw_valid && hw_ready;
  assign xfer      = (state_q == HOLD) && instr_ready;
  assign first_len = hw_len(hw_in);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    need_d  = need_q;
    len_d   = len_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    fetch_d = fetch_q;
    if (flush) begin
      state_d = COLLECT;
      cnt_d   = 2'd0;
      instr_d = 48'h0;
      fetch_d = {flush_addr[ADDR_W-1:1], 1'b0};
    end else if (hw_acc && ((state_q == HOLD) || (cnt_q == 2'd0))) begin
      // New hw0; in HOLD this only happens alongside a transfer.
      instr_d = {hw_in, 32'h0};
      addr_d  = fetch_q;
      need_d  = first_len;
      fetch_d = fetch_q + HW_STEP;
      if (first_len == 2'd1) begin
        state_d = HOLD;
        len_d   = 2'd1;
        cnt_d   = 2'd0;
      end else begin
        state_d = COLLECT;
        cnt_d   = 2'd1;
      end
    end else if (hw_acc) begin
      fetch_d = fetch_q + HW_STEP;
      case (cnt_q)
        2'd1: begin
          instr_d[31:16] = hw_in;
          if (need_q == 2'd2) begin
            state_d = HOLD;
            len_d   = 2'd2;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = 2'd2;
          end
        end
        default: begin
          instr_d[15:0] = hw_in;
          state_d       = HOLD;
          len_d         = 2'd3;
          cnt_d         = 2'd0;
        end
      endcase
    end else if (xfer) begin
      state_d = COLLECT;
      cnt_d   = 2'd0;
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= 2'd0;
      need_q  <= 2'd0;
      len_q   <= 2'd0;
      instr_q <= 48'h0;
      addr_q  <= RESET_ADDR;
      fetch_q <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      need_q  <= need_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
    end
  end

  assign instr       = instr_q;
  assign instr_len   = len_q;
  assign instr_addr  = addr_q;
  assign instr_valid = (state_q == HOLD);

endmodule

// File: tb/tb_instr_halfword_assembler.sv
// Bench for instr_halfword_assembler: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based model.
module tb_instr_halfword_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hw_in;
  logic        hw_valid;
  logic        hw_ready;
  logic        flush;
  logic [31:0] flush_addr;
  logic [47:0] instr;
  logic [1:0]  instr_len;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int passed = 0;

  instr_halfword_assembler dut (
    .clk(clk), .rst_n(rst_n), .hw_in(hw_in), .hw_valid(hw_valid), .hw_ready(hw_ready),
    .flush(flush), .flush_addr(flush_addr), .instr(instr), .instr_len(instr_len),
    .instr_addr(instr_addr), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0, w1, w2;
    int          n;
    logic [47:0] e_instr;
    logic [1:0]  e_len;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [47:0] i;
    logic [1:0]  l;
    logic [31:0] a;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hw_valid = 1'b0; hw_in = 16'h0; flush = 1'b0;
    flush_addr = 32'h0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offers one halfword until it is taken; returns 1 cycle after acceptance.
  task automatic push_hw(input logic [15:0] w);
    int k = 0;
    hw_in = w; hw_valid = 1'b1;
    while (!hw_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) begin
      checks++;
      $display("FAIL hw_accept_timeout: got hw_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    hw_valid = 1'b0;
  endtask

  function automatic int need_of(input logic [15:0] w);
    if (w[15:14] == 2'b00) return 1;
    if (w[15:14] == 2'b11) return 3;
    return 2;
  endfunction

  vec_t tbl[4];
  logic [15:0] part[$];
  logic [31:0] part_addr;
  logic [31:0] fetch;
  exp_t        eq[$];

  initial begin
    tbl[0] = '{16'hC123, 16'hDEAD, 16'hBEEF, 3, 48'hC123_DEAD_BEEF, 2'd3, 32'h0};
    tbl[1] = '{16'h5555, 16'h1111, 16'h0,    2, 48'h5555_1111_0000, 2'd2, 32'h6};
    tbl[2] = '{16'h0007, 16'h0,    16'h0,    1, 48'h0007_0000_0000, 2'd1, 32'hA};
    tbl[3] = '{16'hA000, 16'hFFFF, 16'h0,    2, 48'hA000_FFFF_0000, 2'd2, 32'hC};

    // Reset state and single 16-bit instruction.
    do_reset();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_len", instr_len, 2'd0);
    check("rst_instr", instr, 48'h0);
    check("rst_addr", instr_addr, 32'h0);
    check("rst_hw_ready", hw_ready, 1'b1);
    push_hw(16'h1234);
    check("t1_valid", instr_valid, 1'b1);
    check("t1_instr", instr, 48'h1234_0000_0000);
    check("t1_len", instr_len, 2'd1);
    check("t1_addr", instr_addr, 32'h0);

    // Vector table: back-to-back instructions of every length.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      push_hw(tbl[v].w0);
      if (tbl[v].n > 1) push_hw(tbl[v].w1);
      if (tbl[v].n > 2) push_hw(tbl[v].w2);
      check($sformatf("tbl%0d_valid", v), instr_valid, 1'b1);
      check($sformatf("tbl%0d_instr", v), instr, tbl[v].e_instr);
      check($sformatf("tbl%0d_len", v), instr_len, tbl[v].e_len);
      check($sformatf("tbl%0d_addr", v), instr_addr, tbl[v].e_addr);
    end
    @(posedge clk); #1;
    check("tbl_drain_valid", instr_valid, 1'b0);
    check("tbl_drain_len", instr_len, 2'd2);

    // Backpressure: held stable, hw_ready low, then transfer with a new 16-bit word.
    do_reset();
    instr_ready = 1'b0;
    push_hw(16'h4A01);
    push_hw(16'h8000);
    hw_in = 16'h0003; hw_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", instr_valid, 1'b1);
      check("t3_hold_instr", instr, 48'h4A01_8000_0000);
      check("t3_hold_len", instr_len, 2'd2);
      check("t3_hw_ready", hw_ready, 1'b0);
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    hw_valid = 1'b0;
    check("t3_next_valid", instr_valid, 1'b1);
    check("t3_next_instr", instr, 48'h0003_0000_0000);
    check("t3_next_addr", instr_addr, 32'h4);

    // 16-bit stream: one instruction per cycle.
    do_reset();
    hw_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      hw_in = 16'(c + 1);
      @(posedge clk); #1;
      check("t4_valid", instr_valid, 1'b1);
      check("t4_instr", instr, {16'(c + 1), 32'h0});
      check("t4_addr", instr_addr, 32'(2 * c));
    end
    hw_valid = 1'b0;

    // Flush discards a partial 48-bit instruction.
    do_reset();
    push_hw(16'hC000);
    push_hw(16'h1111);
    flush = 1'b1; flush_addr = 32'h101; hw_in = 16'h0ABC; hw_valid = 1'b1;
    #1 check("t5_hw_ready_flush", hw_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("t5_post_flush_valid", instr_valid, 1'b0);
    check("t5_post_flush_instr", instr, 48'h0);
    @(posedge clk); #1;
    hw_valid = 1'b0;
    check("t5_valid", instr_valid, 1'b1);
    check("t5_instr", instr, 48'h0ABC_0000_0000);
    check("t5_addr", instr_addr, 32'h100);

    // Async reset in the middle of a 32-bit instruction.
    do_reset();
    push_hw(16'h8000);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", instr_valid, 1'b0);
    check("t6_rst_addr", instr_addr, 32'h0);
    check("t6_rst_len", instr_len, 2'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_hw(16'h0007);
    check("t6_valid", instr_valid, 1'b1);
    check("t6_len", instr_len, 2'd1);
    check("t6_addr", instr_addr, 32'h0);

    // Randomized run against the queue model.
    do_reset();
    part.delete(); eq.delete(); fetch = 32'h0; part_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      hw_valid    = ($urandom_range(0, 3) != 0);
      hw_in       = 16'($urandom);
      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      flush_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF9 + 32'($urandom_range(0, 4))) : $urandom;
      @(negedge clk);
      check("rnd_valid", instr_valid, (eq.size() != 0));
      check("rnd_hw_ready", hw_ready, (!flush && ((eq.size() == 0) || instr_ready)));
      if (instr_valid && eq.size() != 0) begin
        check("rnd_instr", instr, eq[0].i);
        check("rnd_len", instr_len, eq[0].l);
        check("rnd_addr", instr_addr, eq[0].a);
      end
      if (flush) begin
        eq.delete(); part.delete();
        fetch = {flush_addr[31:1], 1'b0};
      end else begin
        if (eq.size() != 0 && instr_ready) void'(eq.pop_front());
        if (hw_valid && hw_ready) begin
          if (part.size() == 0) part_addr = fetch;
          part.push_back(hw_in);
          fetch = fetch + 32'd2;
          if (part.size() == need_of(part[0])) begin
            exp_t e;
            e.i = {part[0], (part.size() > 1) ? part[1] : 16'h0, (part.size() > 2) ? part[2] : 16'h0};
            e.l = 2'(part.size());
            e.a = part_addr;
            eq.push_back(e);
            part.delete();
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
